regbank_dump: RTL and testbench
===============================

Name: regbank_dump

Overview:
- Read-side companion to the register bank: on request, walks a range of register-file entries through one bank read port and streams each 32-bit value out as two 16-bit words.
- Sits beside the bank and steals its Rs read port while active.
- Asserts a stall to the core so no writeback or instruction read collides with the scan.
- Used for debug display and for register-state dumps in test benches.

Parameters:
- NREGS, 17, number of bank entries (R0–R15 plus SP at index 16).
- DW, 32, register data width.
- OW, 16, output word width (DW = 2*OW).
- AW, 5, register index width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a dump; ignored unless idle.
- first_idx  input  AW  first register index, latched on accepted start.
- last_idx  input  AW  last register index (inclusive), latched on accepted start.
- rd_addr  output  AW  register index driven to bank read port (Rs) while busy.
- rd_data  input  DW  bank read data (rd1), combinational from rd_addr.
- stall  output  1  high whenever not idle; core must hold and suppress RegW.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
- out_data  output  OW  output word.
- out_idx  output  AW  register index of the current word.
- out_half  output  1  0 = low half [15:0], 1 = high half [31:16].
- busy  output  1  same as stall; provided for the debug consumer.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset, synchronous, dominant over all other inputs, including mid-dump:
  - State returns to IDLE.
  - rd_addr=0, stall=busy=0, out_valid=0, out_data=0, out_idx=0, out_half=0, done=0.
  - Latched range and shadow register cleared.
- States: IDLE, FETCH, SEND_LO, SEND_HI, FIN.
- IDLE:
  - start=1 latches first_idx/last_idx.
  - Latched last is clamped to NREGS-1 if last_idx >= NREGS.
  - If latched first > latched last, go to FIN (zero words sent).
  - Otherwise set idx=first and go to FETCH.
- FETCH (one cycle):
  - rd_addr=idx, registered and stable for the whole cycle.
  - At the cycle end, shadow <= rd_data.
  - Go to SEND_LO.
- SEND_LO:
  - out_valid=1, out_data=shadow[15:0], out_idx=idx, out_half=0.
  - Hold in this state until out_ready=1, then go to SEND_HI.
- SEND_HI:
  - out_valid=1, out_data=shadow[31:16], out_half=1.
  - On out_ready=1: if idx==last go to FIN, else idx <= idx+1 and go to FETCH.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- Handshake rules:
  - Once out_valid rises, out_valid, out_data, out_idx and out_half stay constant until accepted.
  - out_valid is never withdrawn without acceptance, except on rst.
  - out_ready while out_valid=0 has no effect.
- stall/busy:
  - High in FETCH, SEND_LO, SEND_HI and FIN.
  - Low in IDLE, including the cycle start is sampled.
  - The first stalled cycle is the FETCH cycle or the FIN cycle.
- rd_addr holds its last value outside FETCH; the bank read is combinational, so no side effects.
- Latency:
  - start sampled at edge N → FETCH during cycle N+1 → first out_valid in cycle N+2.
  - With out_ready tied high, each register costs 3 cycles.
  - A full 0..16 dump yields 34 words; done occurs 51 cycles after FETCH begins.
- start while not idle is ignored; no queuing.
- idx never wraps: the range is bounded by the clamped last.
- Width: out_idx and rd_addr are AW bits, and idx+1 never exceeds NREGS-1.

Test Plan:
- Reset, then preload R1=0x1234_5678 and R2=0xDEAD_BEEF; start, first=1, last=2, out_ready=1 → words 0x5678, 0x1234, 0xBEEF, 0xDEAD with idx/half (1,0), (1,1), (2,0), (2,1); done pulses once; stall high exactly from FETCH through FIN.
- Full dump, first=0, last=16, SP=1023 after reset → 34 words; last two are 0x03FF and 0x0000 with out_idx=16; done at cycle 51 after the first FETCH.
- Backpressure: out_ready random ~30% duty during the 1..2 dump → out_data, out_idx and out_half stable while out_valid=1 and out_ready=0; same four words in the same order.
- Boundaries:
  - first=5, last=3 → no out_valid, done one cycle after start, stall high one cycle.
  - first=last=16 → exactly two words.
  - last=31 → clamped to 16.
- start pulsed again mid-dump → ignored, sequence unchanged.
- rst asserted in SEND_HI → next cycle all outputs 0 and state IDLE; a new start then works normally.

Source files
------------

// File: rtl/regbank_dump.sv
// regbank_dump: scans a register-bank index range through the Rs read port and streams each entry as two 16-bit words
module regbank_dump #(
   parameter int NREGS = 17,
   parameter int DW    = 32,
   parameter int OW    = 16,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] first_idx,
   input  logic [AW-1:0] last_idx,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          stall,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          out_half,
   output logic          busy,
   output logic          done
);
   typedef enum logic [2:0] {IDLE, FETCH, SEND_LO, SEND_HI, FIN} state_t;
   localparam logic [AW-1:0] LAST_MAX = AW'(NREGS - 1);
   state_t state;
   logic [AW-1:0] idx, last_r, last_c;
   logic [DW-OW-1:0] shadow_hi;
   assign last_c = (last_idx > LAST_MAX) ? LAST_MAX : last_idx;
   assign busy = stall;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         last_r    <= '0;
         shadow_hi <= '0;
         rd_addr   <= '0;
         stall     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_half  <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               last_r <= last_c;
               idx    <= first_idx;
               stall  <= 1'b1;
               if (first_idx > last_c) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else begin
                  state   <= FETCH;
                  rd_addr <= first_idx;
               end
            end
            // low half goes straight out; only the high half needs shadowing
            FETCH: begin
               shadow_hi <= rd_data[DW-1:OW];
               out_valid <= 1'b1;
               out_data  <= rd_data[OW-1:0];
               out_idx   <= idx;
               out_half  <= 1'b0;
               state     <= SEND_LO;
            end
            SEND_LO: if (out_ready) begin
               out_data <= shadow_hi;
               out_half <= 1'b1;
               state    <= SEND_HI;
            end
            SEND_HI: if (out_ready) begin
               out_valid <= 1'b0;
               if (idx == last_r) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else begin
                  idx     <= idx + AW'(1);
                  rd_addr <= idx + AW'(1);
                  state   <= FETCH;
               end
            end
            FIN: begin
               done  <= 1'b0;
               stall <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_regbank_dump.sv
// tb_regbank_dump: queue-based model of the expected word stream checked every cycle, plus directed range tests
module tb_regbank_dump;
   logic        clk = 1'b0;
   logic        rst, start, out_ready, out_valid, out_half, stall, busy, done;
   logic [4:0]  first_idx, last_idx, rd_addr, out_idx;
   logic [31:0] rd_data;
   logic [15:0] out_data;
   logic [31:0] bank [0:16];
   logic [21:0] exp_q[$], log_q[$];
   int total = 0, bad = 0;
   int cyc, nst;

   regbank_dump dut (
      .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
      .rd_addr(rd_addr), .rd_data(rd_data), .stall(stall), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_half(out_half),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   assign rd_data = (rd_addr < 5'd17) ? bank[rd_addr] : 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // every offered word must match the head of the expected stream
   always @(negedge clk) begin
      if (rst) exp_q.delete();
      else begin
         if (out_valid) begin
            if (exp_q.size() == 0) check("extra_word", {10'd0, out_data, out_idx, out_half}, 32'hFFFF_FFFF);
            else begin
               check("word", {10'd0, out_data, out_idx, out_half}, {10'd0, exp_q[0]});
               if (out_ready) begin
                  log_q.push_back({out_data, out_idx, out_half});
                  void'(exp_q.pop_front());
               end
            end
         end
         if (done) check("drained", exp_q.size(), 0);
      end
   end

   task automatic expect_range(input logic [4:0] f, input logic [4:0] l);
      int lc;
      lc = (l > 5'd16) ? 16 : int'(l);
      log_q.delete();
      for (int i = int'(f); i <= lc; i++) begin
         exp_q.push_back({bank[i][15:0], 5'(i), 1'b0});
         exp_q.push_back({bank[i][31:16], 5'(i), 1'b1});
      end
   endtask

   task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit rnd, input bit mid,
                           output int c, output int s);
      expect_range(f, l);
      first_idx = f;
      last_idx  = l;
      start     = 1'b1;
      out_ready = 1'b1;
      check("stall_at_start", stall, 0);
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      s = 0;
      while (!done && c < 400) begin
         if (stall) s++;
         start = (mid && c == 2);
         if (mid) begin first_idx = 5'd0; last_idx = 5'd16; end
         out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      check("done_seen", done, 1);
      if (stall) s++;
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after", busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; first_idx = '0; last_idx = '0;
      for (int i = 0; i < 17; i++) bank[i] = {16'(i * 3 + 16'h0A00), 16'(i * 7 + 16'h5000)};
      bank[1] = 32'h1234_5678;
      bank[2] = 32'hDEAD_BEEF;
      bank[16] = 32'd1023;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_addr", rd_addr, 0);
      check("rst_stall", stall, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_dump(5'd1, 5'd2, 1'b0, 1'b0, cyc, nst);
      check("t1_cycles", cyc, 6);
      check("t1_stall_cycles", nst, 7);
      check("t1_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         check("t1_w0", log_q[0], {16'h5678, 5'd1, 1'b0});
         check("t1_w1", log_q[1], {16'h1234, 5'd1, 1'b1});
         check("t1_w2", log_q[2], {16'hBEEF, 5'd2, 1'b0});
         check("t1_w3", log_q[3], {16'hDEAD, 5'd2, 1'b1});
      end

      run_dump(5'd0, 5'd16, 1'b0, 1'b0, cyc, nst);
      check("full_cycles", cyc, 51);
      check("full_count", log_q.size(), 34);
      if (log_q.size() == 34) begin
         check("full_w32", log_q[32], {16'h03FF, 5'd16, 1'b0});
         check("full_w33", log_q[33], {16'h0000, 5'd16, 1'b1});
      end

      run_dump(5'd1, 5'd2, 1'b1, 1'b0, cyc, nst);
      check("bp_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         check("bp_w0", log_q[0], {16'h5678, 5'd1, 1'b0});
         check("bp_w3", log_q[3], {16'hDEAD, 5'd2, 1'b1});
      end

      run_dump(5'd5, 5'd3, 1'b0, 1'b0, cyc, nst);
      check("empty_cycles", cyc, 0);
      check("empty_stall", nst, 1);
      check("empty_count", log_q.size(), 0);

      run_dump(5'd16, 5'd16, 1'b0, 1'b0, cyc, nst);
      check("sp_count", log_q.size(), 2);

      run_dump(5'd10, 5'd31, 1'b0, 1'b0, cyc, nst);
      check("clamp_count", log_q.size(), 14);
      check("clamp_cycles", cyc, 21);

      run_dump(5'd1, 5'd2, 1'b0, 1'b1, cyc, nst);
      check("mid_start_count", log_q.size(), 4);
      check("mid_start_cycles", cyc, 6);

      expect_range(5'd1, 5'd2);
      first_idx = 5'd1; last_idx = 5'd2; start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rst_hi_half", out_half, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_idx", out_idx, 0);
      check("mid_rst_half", out_half, 0);
      check("mid_rst_addr", rd_addr, 0);
      @(posedge clk); #1;

      run_dump(5'd3, 5'd4, 1'b0, 1'b0, cyc, nst);
      check("after_rst_cycles", cyc, 6);
      check("after_rst_count", log_q.size(), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
